// File: rtl/req_encoder_8to3.sv
// Sequential multi-hot to binary encoder: accepts a request vector and emits
// the index of each set bit, lowest first, one per output handshake.
module req_encoder_8to3 #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic [W:0]   pend_cnt
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pend;

    logic [W-1:0] w_low_idx;
    logic [W:0]   w_cnt;
    logic         w_drain;
    logic         w_xfer;
    logic         w_accept;

    // NOTE: combinational blocks assign a default first so no path holds a value (no latch).
    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) w_low_idx = W'(i);
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + (W+1)'(r_pend[i]);
        end
    end

    // Outputs are forced quiet while rst is high so no beat can transfer then.
    assign w_drain   = !rst && (r_state == DRAIN);
    assign out_valid = w_drain;
    assign out_idx   = w_drain ? w_low_idx : '0;
    assign pend_cnt  = w_drain ? w_cnt : '0;
    assign out_last  = w_drain && (w_cnt == (W+1)'(1));

    assign in_ready  = !rst && ((r_state == IDLE) || (out_ready && out_last));
    assign w_xfer    = out_valid && out_ready;
    assign w_accept  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else if (w_accept) begin
            // Covers both IDLE loads and a new vector on the last beat of the previous one.
            r_pend  <= in_vec;
            r_state <= (in_vec != '0) ? DRAIN : IDLE;
        end else if (w_xfer) begin
            // Clearing the lowest set bit is exactly the bit at out_idx.
            r_pend  <= r_pend & (r_pend - N'(1));
            r_state <= out_last ? IDLE : DRAIN;
        end
    end

endmodule
